cart_rom_fetch: RTL and testbench
=================================

# cart_rom_fetch

Memory-fetch stage directly downstream of the cartridge mappers. It takes the mapped byte address and output-enable produced by a mapper and turns each CPU read into one SDRAM word request. It holds the Z80 in wait until data returns, then presents the selected byte on the CPU data bus. Out-of-image reads, and requests the memory never answers, complete with 8'hFF.

## Interface
Parameters:
- TIMEOUT, 8'd200: maximum cycles to wait for `sdram_ack` before forcing completion.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rom_size  in  25  cartridge image size in bytes; 0 means no image.
- mem_addr  in  25  mapped byte address from the mapper.
- mem_oe  in  1  mapper selects this cycle (slot cs).
- rd  in  1  CPU memory read strobe.
- sdram_addr  out  24  word address, equal to `mem_addr[24:1]` latched.
- sdram_req  out  1  request, level held until ack.
- sdram_ack  in  1  one-cycle pulse; data is valid in the same cycle.
- sdram_dout  in  16  read word; low byte is the even address.
- d_to_cpu  out  8  read data.
- wait_n  out  1  Z80 WAIT, active-low.
- busy  out  1  fetch in progress, for debug and arbitration.

## Operation
- Read start: rising edge of `rd_sel = mem_oe & rd`, detected against a registered copy `rd_sel_q`.
- States:
  - IDLE → (start & in-range & miss) → REQ.
  - IDLE → (start & out-of-range) → DONE.
  - IDLE → (start & hit, cache enabled) → DONE.
  - REQ: `sdram_req`=1, address latched. On `sdram_ack`, latch the byte and go to DONE. When the timeout counter reaches TIMEOUT, latch 8'hFF and go to DONE.
  - DONE: hold `d_to_cpu` until `rd_sel` falls, then go to IDLE.
- In-range test: `mem_addr < rom_size`. `rom_size`=0 means every read is out of range.
- Byte select: `mem_addr[0]` chooses `sdram_dout[15:8]` when 1, `[7:0]` when 0.
- `wait_n` = ~((start & needs_fetch) | state==REQ). It is combinational so WAIT is low in the same cycle the read begins.
- `busy` = state==REQ.
- Writes (`rd`=0) are ignored. ROM is never written.
- If `rd_sel` drops while in REQ (CPU aborted), complete the request, discard the result and return to IDLE.
- Timeout counter: 8 bits, cleared on entry to REQ, saturating.

## Timing
- Reset values:
  - `sdram_req`=0, `wait_n`=1, `busy`=0.
  - `d_to_cpu`=8'hFF, `sdram_addr`=0.
  - state=IDLE, timeout counter=0.
  - cache tag invalid.
- Miss latency: `sdram_req` rises on the clock edge after the start. `d_to_cpu` is valid and `wait_n`=1 on the edge after the `sdram_ack` cycle.
- `sdram_req` drops on the edge after `sdram_ack`. An ack arriving while not in REQ is ignored.
- Out-of-range read: `wait_n` stays 1 and `d_to_cpu`=FF from the next edge. Zero SDRAM traffic.
- Back-to-back reads: a new start is accepted only in IDLE. Each read requires `rd_sel` to fall and rise again.
- Asynchronous reset mid-REQ: state, outputs and cache are cleared immediately. An ack arriving afterwards is ignored.

## Configuration
- `CART_FETCH_CACHE_EN` defined: a one-word cache.
  - Contents: 24-bit tag, valid bit, 16-bit data, updated on every accepted `sdram_ack`.
  - A start whose `mem_addr[24:1]` equals a valid tag completes from the cache: `wait_n` stays 1, `d_to_cpu` is valid on the next edge, and no request is issued.
  - A rising edge of `rom_size` change or of `reset` invalidates the cache.
- Macro absent:
  - Cache logic is not built.
  - Every in-range read issues an SDRAM request.

## Test plan
- Miss: `rom_size`=32768, read 0x0005, ack after 3 cycles with `sdram_dout`=16'hC3A5.
  - `sdram_addr`=0x000002 and `sdram_req` is held 3 cycles.
  - `d_to_cpu`=8'hC3, and `wait_n` returns to 1 one cycle after the ack.
- Out of range: `rom_size`=16384, read 0x4000.
  - `sdram_req` never asserts, `wait_n` stays 1, `d_to_cpu`=8'hFF.
- Timeout: no ack is ever given.
  - `wait_n` is low for exactly TIMEOUT+1 cycles, `d_to_cpu`=8'hFF, state returns to IDLE.
- Reset during REQ, followed by a late ack:
  - `sdram_req`=0 and `wait_n`=1 immediately.
  - The late ack leaves `d_to_cpu`=8'hFF.
- Cache (macro defined): read 0x0004, then 0x0005.
  - The second read issues no request and returns `sdram_dout[15:8]` of the first ack.
  - With the macro absent, both reads issue a request.
- Aborted read: `rd` drops while in REQ, then the ack arrives.
  - Returns to IDLE.
  - The next read of a different address fetches correctly.

Source files
------------

// File: rtl/cart_rom_fetch.sv
// Cartridge ROM fetch stage: turns each mapped CPU read into one SDRAM word request and holds WAIT until data returns.
// Optional one-word read cache is built when CART_FETCH_CACHE_EN is defined.
module cart_rom_fetch #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] rom_size,
    input  logic [24:0] mem_addr,
    input  logic        mem_oe,
    input  logic        rd,
    output logic [23:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic [15:0] sdram_dout,
    output logic [7:0]  d_to_cpu,
    output logic        wait_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic        rd_sel;
    logic        rd_sel_q;
    logic        abort_reg;
    logic        addr_lsb_reg;
    logic [7:0]  timeout_cnt_reg;
    logic [7:0]  timeout_cnt_next;
    logic        start;
    logic        in_range;
    logic        hit;
    logic [7:0]  hit_byte;
    logic        needs_fetch;
    logic [7:0]  ack_byte;
    logic        abort_now;

    assign rd_sel    = mem_oe & rd;
    assign start     = rd_sel & ~rd_sel_q & (state_reg == IDLE);
    // rom_size == 0 makes this false for every address, so no special case is needed.
    assign in_range  = (mem_addr < rom_size);
    assign needs_fetch = in_range & ~hit;
    assign ack_byte  = addr_lsb_reg ? sdram_dout[15:8] : sdram_dout[7:0];
    assign abort_now = abort_reg | ~rd_sel;
    assign timeout_cnt_next = (timeout_cnt_reg == 8'hFF) ? timeout_cnt_reg : timeout_cnt_reg + 8'd1;

    // WAIT must drop in the very cycle the read starts, hence combinational.
    assign wait_n = ~((start & needs_fetch) | (state_reg == REQ));
    assign busy   = (state_reg == REQ);

`ifdef CART_FETCH_CACHE_EN
    logic [23:0] tag_reg;
    logic        valid_reg;
    logic [15:0] data_reg;
    logic [24:0] rom_size_q;

    assign hit      = valid_reg & (tag_reg == mem_addr[24:1]);
    assign hit_byte = mem_addr[0] ? data_reg[15:8] : data_reg[7:0];

    // A new image size means stale contents; invalidation wins over a same-cycle fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_reg    <= 24'd0;
            valid_reg  <= 1'b0;
            data_reg   <= 16'd0;
            rom_size_q <= 25'd0;
        end else begin
            rom_size_q <= rom_size;
            if (rom_size != rom_size_q) begin
                valid_reg <= 1'b0;
            end else if ((state_reg == REQ) && sdram_ack) begin
                valid_reg <= 1'b1;
                tag_reg   <= sdram_addr;
                data_reg  <= sdram_dout;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_byte = 8'hFF;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            rd_sel_q        <= 1'b0;
            abort_reg       <= 1'b0;
            addr_lsb_reg    <= 1'b0;
            timeout_cnt_reg <= 8'd0;
            sdram_req       <= 1'b0;
            sdram_addr      <= 24'd0;
            d_to_cpu        <= 8'hFF;
        end else begin
            rd_sel_q <= rd_sel;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (!in_range) begin
                            d_to_cpu  <= 8'hFF;
                            state_reg <= DONE;
                        end else if (hit) begin
                            d_to_cpu  <= hit_byte;
                            state_reg <= DONE;
                        end else begin
                            sdram_req       <= 1'b1;
                            sdram_addr      <= mem_addr[24:1];
                            addr_lsb_reg    <= mem_addr[0];
                            timeout_cnt_reg <= 8'd0;
                            abort_reg       <= 1'b0;
                            state_reg       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!rd_sel) begin
                        abort_reg <= 1'b1;
                    end
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (abort_now) begin
                            state_reg <= IDLE;
                        end else begin
                            d_to_cpu  <= ack_byte;
                            state_reg <= DONE;
                        end
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_next;
                        if (timeout_cnt_next >= TIMEOUT) begin
                            sdram_req <= 1'b0;
                            if (abort_now) begin
                                state_reg <= IDLE;
                            end else begin
                                d_to_cpu  <= 8'hFF;
                                state_reg <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!rd_sel) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Bench for cart_rom_fetch: per-cycle comparison against a behavioural read model plus directed literal checks.
module tb_cart_rom_fetch;

    localparam logic [7:0] TIMEOUT = 8'd200;
`ifdef CART_FETCH_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] rom_size = 25'd0;
    logic [24:0] mem_addr = 25'd0;
    logic        mem_oe = 1'b0;
    logic        rd = 1'b0;
    logic        sdram_ack = 1'b0;
    logic [15:0] sdram_dout = 16'd0;
    logic [23:0] sdram_addr;
    logic        sdram_req;
    logic [7:0]  d_to_cpu;
    logic        wait_n;
    logic        busy;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int req_cnt = 0;
    int wait_cnt = 0;

    always #5 clk = ~clk;

    cart_rom_fetch #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .rom_size(rom_size),
        .mem_addr(mem_addr),
        .mem_oe(mem_oe),
        .rd(rd),
        .sdram_addr(sdram_addr),
        .sdram_req(sdram_req),
        .sdram_ack(sdram_ack),
        .sdram_dout(sdram_dout),
        .d_to_cpu(d_to_cpu),
        .wait_n(wait_n),
        .busy(busy)
    );

    // Behavioural model: what the CPU-visible read should look like.
    bit          m_fetching;
    bit          m_showing;
    bit          m_aborted;
    int          m_age;
    logic [7:0]  m_data;
    logic [23:0] m_addr;
    bit          m_lsb;
    bit          m_prev_sel;
    logic [24:0] m_prev_size;
    bit          c_valid;
    logic [23:0] c_tag;
    logic [15:0] c_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        bit sel;
        bit chg;
        bit was_f;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_fetching = 0; m_showing = 0; m_aborted = 0; m_age = 0;
                m_data = 8'hFF; m_addr = 24'd0; m_lsb = 0; m_prev_sel = 0;
                m_prev_size = 25'd0; c_valid = 0; c_tag = 24'd0; c_word = 16'd0;
            end else begin
                sel   = mem_oe && rd;
                chg   = (rom_size != m_prev_size);
                was_f = m_fetching;
                if (m_fetching) begin
                    if (!sel) m_aborted = 1;
                    if (sdram_ack) begin
                        m_fetching = 0;
                        if (!m_aborted) begin
                            m_showing = 1;
                            m_data = m_lsb ? sdram_dout[15:8] : sdram_dout[7:0];
                        end
                    end else begin
                        m_age++;
                        if (m_age >= int'(TIMEOUT)) begin
                            m_fetching = 0;
                            if (!m_aborted) begin
                                m_showing = 1;
                                m_data = 8'hFF;
                            end
                        end
                    end
                end else if (m_showing) begin
                    if (!sel) m_showing = 0;
                end else if (sel && !m_prev_sel) begin
                    if (!(mem_addr < rom_size)) begin
                        m_showing = 1;
                        m_data = 8'hFF;
                    end else if (CACHE_EN && c_valid && c_tag == mem_addr[24:1]) begin
                        m_showing = 1;
                        m_data = mem_addr[0] ? c_word[15:8] : c_word[7:0];
                    end else begin
                        m_fetching = 1;
                        m_age = 0;
                        m_aborted = 0;
                        m_addr = mem_addr[24:1];
                        m_lsb = mem_addr[0];
                    end
                end
                if (chg) begin
                    c_valid = 0;
                end else if (was_f && sdram_ack) begin
                    c_valid = 1;
                    c_tag = m_addr;
                    c_word = sdram_dout;
                end
                m_prev_sel = sel;
                m_prev_size = rom_size;
            end
        end
    end

    initial begin : compare
        bit sel;
        bit st;
        bit need;
        forever begin
            @(negedge clk);
            if (sdram_req) req_cnt++;
            if (!wait_n) wait_cnt++;
            if (chk_en) begin
                sel  = mem_oe && rd;
                st   = sel && !m_prev_sel && !m_fetching && !m_showing;
                need = (mem_addr < rom_size) && !(CACHE_EN && c_valid && c_tag == mem_addr[24:1]);
                chk("cyc_sdram_req", {31'd0, sdram_req}, {31'd0, m_fetching});
                chk("cyc_busy", {31'd0, busy}, {31'd0, m_fetching});
                chk("cyc_wait_n", {31'd0, wait_n}, {31'd0, !(m_fetching || (st && need))});
                chk("cyc_d_to_cpu", {24'd0, d_to_cpu}, {24'd0, m_data});
                chk("cyc_sdram_addr", {8'd0, sdram_addr}, {8'd0, m_addr});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_read(input logic [24:0] a);
        mem_addr = a;
        mem_oe = 1'b1;
        rd = 1'b1;
    endtask

    task automatic end_read();
        mem_oe = 1'b0;
        rd = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0;
        int w0;
        bit done;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sdram_req", {31'd0, sdram_req}, 32'd0);
        chk("rst_wait_n", {31'd0, wait_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_d_to_cpu", {24'd0, d_to_cpu}, 32'hFF);
        chk("rst_sdram_addr", {8'd0, sdram_addr}, 32'd0);
        step();
        reset = 1'b0;
        chk_en = 1'b1;

        // Miss: 0x0005 in a 32 KiB image, ack in the third request cycle.
        rom_size = 25'd32768;
        step();
        r0 = req_cnt; w0 = wait_cnt;
        start_read(25'h0005);
        step();
        chk("miss_addr", {8'd0, sdram_addr}, 32'h000002);
        chk("miss_req_up", {31'd0, sdram_req}, 32'd1);
        step();
        step();
        sdram_ack = 1'b1; sdram_dout = 16'hC3A5;
        step();
        sdram_ack = 1'b0; sdram_dout = 16'h0000;
        chk("miss_data", {24'd0, d_to_cpu}, 32'hC3);
        chk("miss_wait_n", {31'd0, wait_n}, 32'd1);
        chk("miss_req_down", {31'd0, sdram_req}, 32'd0);
        step();
        end_read();
        step(); step();
        chk("miss_req_cycles", req_cnt - r0, 32'd3);
        chk("miss_wait_cycles", wait_cnt - w0, 32'd4);

        // Out of range: 0x4000 in a 16 KiB image.
        rom_size = 25'd16384;
        step();
        r0 = req_cnt; w0 = wait_cnt;
        start_read(25'h4000);
        step();
        chk("oor_data", {24'd0, d_to_cpu}, 32'hFF);
        step();
        end_read();
        step(); step();
        chk("oor_req_cycles", req_cnt - r0, 32'd0);
        chk("oor_wait_cycles", wait_cnt - w0, 32'd0);

        // Timeout: request never answered.
        rom_size = 25'd32768;
        step();
        w0 = wait_cnt;
        start_read(25'h0100);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            if (wait_n) done = 1'b1;
        end
        chk("to_bound", {31'd0, done}, 32'd1);
        chk("to_wait_cycles", wait_cnt - w0, {24'd0, TIMEOUT} + 32'd1);
        chk("to_data", {24'd0, d_to_cpu}, 32'hFF);
        chk("to_busy", {31'd0, busy}, 32'd0);
        end_read();
        step(); step();

        // Reset in the middle of a request, then late acks.
        start_read(25'h0008);
        step();
        step();
        reset = 1'b1;
        end_read();
        #1;
        chk("rstreq_sdram_req", {31'd0, sdram_req}, 32'd0);
        chk("rstreq_wait_n", {31'd0, wait_n}, 32'd1);
        chk("rstreq_data", {24'd0, d_to_cpu}, 32'hFF);
        step();
        sdram_ack = 1'b1; sdram_dout = 16'h1234;
        step();
        sdram_ack = 1'b0;
        reset = 1'b0;
        step();
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0; sdram_dout = 16'h0000;
        step();
        chk("late_ack_data", {24'd0, d_to_cpu}, 32'hFF);
        chk("late_ack_req", {31'd0, sdram_req}, 32'd0);

        // Cache: 0x0004 then 0x0005 share one word.
        r0 = req_cnt;
        start_read(25'h0004);
        step();
        step();
        sdram_ack = 1'b1; sdram_dout = 16'h5A3C;
        step();
        sdram_ack = 1'b0; sdram_dout = 16'h0000;
        chk("c1_data", {24'd0, d_to_cpu}, 32'h3C);
        chk("c1_req_cycles", req_cnt - r0, 32'd2);
        end_read();
        step();
        r0 = req_cnt;
        start_read(25'h0005);
        step();
        if (sdram_req) begin
            sdram_ack = 1'b1; sdram_dout = 16'h5A3C;
            step();
            sdram_ack = 1'b0; sdram_dout = 16'h0000;
        end
        chk("c2_data", {24'd0, d_to_cpu}, 32'h5A);
        end_read();
        step(); step();
        chk("c2_req_cycles", req_cnt - r0, CACHE_EN ? 32'd0 : 32'd1);

        // Aborted read: rd drops during the request, ack result is discarded.
        start_read(25'h0010);
        step();
        end_read();
        step();
        sdram_ack = 1'b1; sdram_dout = 16'h1111;
        step();
        sdram_ack = 1'b0; sdram_dout = 16'h0000;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wait_n", {31'd0, wait_n}, 32'd1);
        chk("abort_data_kept", {24'd0, d_to_cpu}, 32'h5A);
        step();
        start_read(25'h0021);
        step();
        chk("after_abort_addr", {8'd0, sdram_addr}, 32'h000010);
        sdram_ack = 1'b1; sdram_dout = 16'hBEEF;
        step();
        sdram_ack = 1'b0; sdram_dout = 16'h0000;
        chk("after_abort_data", {24'd0, d_to_cpu}, 32'hBE);
        end_read();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
